// File: rtl/measurement_sequencer.sv
// Scheduler for the dual-slope measurement core: triggers, waits for the finish interrupt,
// captures the count and hands it out over valid/ready. Optional averaging: MEAS_AVG_EN.
module measurement_sequencer #(
    parameter int INTERVAL_W     = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int AVG_LOG2       = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic                  single_i,
    input  logic [INTERVAL_W-1:0] interval_i,
    output logic                  trigger_o,
    input  logic                  interrupt_i,
    output logic                  interrupt_clear_o,
    input  logic [11:0]           measurement_count_i,
    output logic [11:0]           result_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic                  busy_o,
    output logic                  timeout_o
);

    // state   | meaning
    // IDLE    | waiting for enable_i or a single_i request
    // TRIG    | one-cycle trigger pulse to the core
    // WAIT    | waiting for the core interrupt, timeout running
    // CAPTURE | sampling the measurement count
    // CLEAR   | holding interrupt clear until the core drops its flag
    // OUTPUT  | result offered until accepted
    // GAP     | idle interval before the next trigger

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 2 || AVG_LOG2 < 0) begin : g_param_check
        $error("measurement_sequencer: TIMEOUT_CYCLES must be >= 2 and AVG_LOG2 >= 0");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_CAPTURE,
        S_CLEAR,
        S_OUTPUT,
        S_GAP
    } state_t;

    state_t                state;
    logic                  single_flag;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [INTERVAL_W-1:0] gap_cnt;

`ifdef MEAS_AVG_EN
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(1 << AVG_LOG2);

    logic [ACC_W-1:0] acc;
    logic [SMP_W-1:0] sample_cnt;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state             <= S_IDLE;
            single_flag       <= 1'b0;
            tmo_cnt           <= '0;
            gap_cnt           <= '0;
            trigger_o         <= 1'b0;
            interrupt_clear_o <= 1'b0;
            result_o          <= 12'd0;
            result_valid_o    <= 1'b0;
            busy_o            <= 1'b0;
            timeout_o         <= 1'b0;
`ifdef MEAS_AVG_EN
            acc               <= '0;
            sample_cnt        <= '0;
`endif
        end else begin
            trigger_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (single_i) begin
                        state       <= S_TRIG;
                        single_flag <= 1'b1;
                        timeout_o   <= 1'b0;
                        trigger_o   <= 1'b1;
                        busy_o      <= 1'b1;
                    end else if (enable_i) begin
                        state     <= S_TRIG;
                        trigger_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end

                S_TRIG: begin
                    tmo_cnt <= TMO_LOAD;
                    state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (interrupt_i) begin
                        interrupt_clear_o <= 1'b1;
                        state             <= S_CAPTURE;
                    end else if (tmo_cnt == '0) begin
                        timeout_o <= 1'b1;
                        gap_cnt   <= interval_i;
                        state     <= S_GAP;
`ifdef MEAS_AVG_EN
                        acc        <= '0;
                        sample_cnt <= '0;
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end

                S_CAPTURE: begin
                    timeout_o <= 1'b0;
`ifdef MEAS_AVG_EN
                    acc        <= acc + ACC_W'(measurement_count_i);
                    sample_cnt <= sample_cnt + SMP_W'(1);
`else
                    result_o   <= measurement_count_i;
`endif
                    state <= S_CLEAR;
                end

                S_CLEAR: begin
                    if (!interrupt_i) begin
                        interrupt_clear_o <= 1'b0;
`ifdef MEAS_AVG_EN
                        if (sample_cnt == SMP_LAST) begin
                            result_o       <= acc[ACC_W-1:AVG_LOG2];
                            acc            <= '0;
                            sample_cnt     <= '0;
                            result_valid_o <= 1'b1;
                            state          <= S_OUTPUT;
                        end else begin
                            gap_cnt <= interval_i;
                            state   <= S_GAP;
                        end
`else
                        result_valid_o <= 1'b1;
                        state          <= S_OUTPUT;
`endif
                    end
                end

                S_OUTPUT: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        if (single_flag) begin
                            single_flag <= 1'b0;
                            busy_o      <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            gap_cnt <= interval_i;
                            state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    // a pending single request keeps the sequencer running after a timeout
                    if (!enable_i && !single_flag) begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
`ifdef MEAS_AVG_EN
                        acc        <= '0;
                        sample_cnt <= '0;
`endif
                    end else if (gap_cnt == '0) begin
                        trigger_o <= 1'b1;
                        state     <= S_TRIG;
                    end else begin
                        gap_cnt <= gap_cnt - INTERVAL_W'(1);
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_measurement_sequencer.sv
// Directed bench for measurement_sequencer with a small behavioural model of the core.
module tb_measurement_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        single_i = 1'b0;
    logic [15:0] interval_i = 16'd0;
    logic        trigger_o;
    logic        interrupt_i = 1'b0;
    logic        interrupt_clear_o;
    logic [11:0] measurement_count_i = 12'd0;
    logic [11:0] result_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic        busy_o;
    logic        timeout_o;

    measurement_sequencer #(
        .INTERVAL_W    (16),
        .TIMEOUT_CYCLES(64),
        .AVG_LOG2      (2)
    ) dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .enable_i           (enable_i),
        .single_i           (single_i),
        .interval_i         (interval_i),
        .trigger_o          (trigger_o),
        .interrupt_i        (interrupt_i),
        .interrupt_clear_o  (interrupt_clear_o),
        .measurement_count_i(measurement_count_i),
        .result_o           (result_o),
        .result_valid_o     (result_valid_o),
        .result_ready_i     (result_ready_i),
        .busy_o             (busy_o),
        .timeout_o          (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int trig_cnt = 0;
    int last_trig = 0;
    int clr_cyc  = 0;
    int valid_cyc = 0;

    // core model
    logic        core_en    = 1'b1;
    logic        core_armed = 1'b0;
    int          core_delay = 50;
    int          core_timer = 0;
    logic [11:0] core_count = 12'd0;
    logic [11:0] core_val   = 12'd0;
    logic [11:0] cnt_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
        cyc++;
        if (trigger_o) begin
            trig_cnt++;
            last_trig = cyc;
            if (core_en) begin
                core_armed = 1'b1;
                core_timer = core_delay;
                core_val   = (cnt_q.size() > 0) ? cnt_q.pop_front() : core_count;
            end
        end else if (core_armed) begin
            core_timer--;
            if (core_timer == 0) begin
                core_armed          = 1'b0;
                interrupt_i         = 1'b1;
                measurement_count_i = core_val;
            end
        end
        if (interrupt_clear_o) begin
            clr_cyc++;
            interrupt_i = 1'b0;
        end
        if (result_valid_o) valid_cyc++;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (result_valid_o) break;
        end
        chk(tag, {31'd0, result_valid_o}, 32'd1);
    endtask

    task automatic reset_now();
        rst_n_i     = 1'b0;
        core_armed  = 1'b0;
        interrupt_i = 1'b0;
        #1;
    endtask

    int t0, t1, base_trig, base_valid, bad, h;

    initial begin
        #2;
        reset_now();
        repeat (3) cycle();
        chk("rst_trigger", {31'd0, trigger_o}, 32'd0);
        chk("rst_clear", {31'd0, interrupt_clear_o}, 32'd0);
        chk("rst_result", {20'd0, result_o}, 32'd0);
        chk("rst_valid", {31'd0, result_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        rst_n_i = 1'b1;
        cycle();

`ifndef MEAS_AVG_EN
        // single measurement, interval 0
        core_delay = 50;
        core_count = 12'h3A5;
        clr_cyc    = 0;
        single_i   = 1'b1;
        cycle();
        single_i = 1'b0;
        chk("single_trigger", {31'd0, trigger_o}, 32'd1);
        chk("single_busy", {31'd0, busy_o}, 32'd1);
        t0 = last_trig;
        base_trig = trig_cnt;
        wait_valid("single_valid", 100);
        chk("single_latency", cyc - t0, 32'd53);
        chk("single_result", {20'd0, result_o}, 32'h3A5);
        chk("single_clear_cycles", clr_cyc, 32'd2);
        repeat (5) cycle();
        chk("single_valid_held", {31'd0, result_valid_o}, 32'd1);
        result_ready_i = 1'b1;
        cycle();
        chk("single_valid_drop", {31'd0, result_valid_o}, 32'd0);
        chk("single_idle", {31'd0, busy_o}, 32'd0);
        chk("single_one_trigger", trig_cnt - base_trig, 32'd0);
        chk("single_result_hold", {20'd0, result_o}, 32'h3A5);

        // continuous, interval 10
        interval_i = 16'd10;
        cnt_q.push_back(12'h123);
        cnt_q.push_back(12'h456);
        enable_i = 1'b1;
        cycle();
        chk("cont_trigger", {31'd0, trigger_o}, 32'd1);
        t0 = last_trig;
        wait_valid("cont_valid1", 100);
        chk("cont_result1", {20'd0, result_o}, 32'h123);
        base_trig = trig_cnt;
        for (int i = 0; i < 100 && trig_cnt == base_trig; i++) cycle();
        t1 = last_trig;
        chk("cont_spacing", t1 - t0, 32'd65);
        wait_valid("cont_valid2", 100);
        chk("cont_result2", {20'd0, result_o}, 32'h456);
        repeat (3) cycle();
        chk("cont_gap_busy", {31'd0, busy_o}, 32'd1);
        enable_i = 1'b0;
        cycle();
        chk("cont_gap_to_idle", {31'd0, busy_o}, 32'd0);
        base_trig = trig_cnt;
        repeat (80) cycle();
        chk("cont_no_trigger", trig_cnt - base_trig, 32'd0);

        // backpressure
        interval_i     = 16'd0;
        result_ready_i = 1'b0;
        core_delay     = 20;
        core_count     = 12'h7E1;
        enable_i       = 1'b1;
        cycle();
        wait_valid("bp_valid", 100);
        base_trig = trig_cnt;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (!result_valid_o || result_o !== 12'h7E1) bad++;
        end
        chk("bp_stable", bad, 32'd0);
        chk("bp_no_trigger", trig_cnt - base_trig, 32'd0);
        result_ready_i = 1'b1;
        core_count     = 12'h0F0;
        cycle();
        chk("bp_valid_drop", {31'd0, result_valid_o}, 32'd0);
        chk("bp_gap_busy", {31'd0, busy_o}, 32'd1);
        cycle();
        chk("bp_retrigger", {31'd0, trigger_o}, 32'd1);
        enable_i = 1'b0;
        base_trig = trig_cnt;
        wait_valid("bp_late_valid", 100);
        chk("bp_late_result", {20'd0, result_o}, 32'h0F0);
        repeat (2) cycle();
        chk("bp_late_idle", {31'd0, busy_o}, 32'd0);
        chk("bp_late_no_trigger", trig_cnt - base_trig, 32'd0);

        // timeout with TIMEOUT_CYCLES = 64, then recovery via the single retry
        core_en  = 1'b0;
        single_i = 1'b1;
        cycle();
        single_i = 1'b0;
        chk("tmo_trigger", {31'd0, trigger_o}, 32'd1);
        t0 = last_trig;
        base_valid = valid_cyc;
        repeat (64) cycle();
        chk("tmo_not_yet", {31'd0, timeout_o}, 32'd0);
        cycle();
        chk("tmo_rise_cycle", cyc - t0, 32'd65);
        chk("tmo_set", {31'd0, timeout_o}, 32'd1);
        chk("tmo_no_valid", valid_cyc - base_valid, 32'd0);
        core_en    = 1'b1;
        core_delay = 10;
        core_count = 12'h2C4;
        cycle();
        chk("tmo_retry_trigger", {31'd0, trigger_o}, 32'd1);
        chk("tmo_sticky", {31'd0, timeout_o}, 32'd1);
        wait_valid("tmo_recover_valid", 100);
        chk("tmo_recover_cycle", cyc - t0, 32'd79);
        chk("tmo_cleared", {31'd0, timeout_o}, 32'd0);
        chk("tmo_recover_result", {20'd0, result_o}, 32'h2C4);
        cycle();
        chk("tmo_idle", {31'd0, busy_o}, 32'd0);
`else
        // averaging of four samples
        interval_i     = 16'd0;
        result_ready_i = 1'b1;
        core_delay     = 8;
        cnt_q.push_back(12'd100);
        cnt_q.push_back(12'd101);
        cnt_q.push_back(12'd102);
        cnt_q.push_back(12'd104);
        base_trig  = trig_cnt;
        base_valid = valid_cyc;
        enable_i   = 1'b1;
        wait_valid("avg_valid", 300);
        chk("avg_triggers", trig_cnt - base_trig, 32'd4);
        chk("avg_valid_count", valid_cyc - base_valid, 32'd1);
        chk("avg_result", {20'd0, result_o}, 32'd101);
        enable_i = 1'b0;
        repeat (3) cycle();
        chk("avg_idle", {31'd0, busy_o}, 32'd0);
        chk("avg_result_hold", {20'd0, result_o}, 32'd101);
        core_count = 12'h9AB;
`endif

        // reset during WAIT
        result_ready_i = 1'b1;
        core_delay     = 30;
        core_count     = 12'h555;
        single_i       = 1'b1;
        cycle();
        single_i = 1'b0;
        repeat (5) cycle();
        chk("rw_busy_before", {31'd0, busy_o}, 32'd1);
        reset_now();
        chk("rw_busy", {31'd0, busy_o}, 32'd0);
        chk("rw_trigger", {31'd0, trigger_o}, 32'd0);
        chk("rw_clear", {31'd0, interrupt_clear_o}, 32'd0);
        chk("rw_result", {20'd0, result_o}, 32'd0);
        repeat (2) cycle();
        rst_n_i = 1'b1;
        base_trig = trig_cnt;
        repeat (40) cycle();
        chk("rw_no_trigger", trig_cnt - base_trig, 32'd0);
        chk("rw_idle", {31'd0, busy_o}, 32'd0);

        // reset during OUTPUT
        result_ready_i = 1'b0;
        core_delay     = 5;
        core_count     = 12'h9AB;
        single_i       = 1'b1;
        cycle();
        single_i = 1'b0;
        wait_valid("ro_valid", 200);
        chk("ro_result_before", {20'd0, result_o}, 32'h9AB);
        reset_now();
        chk("ro_valid_cleared", {31'd0, result_valid_o}, 32'd0);
        chk("ro_result_cleared", {20'd0, result_o}, 32'd0);
        chk("ro_busy", {31'd0, busy_o}, 32'd0);
        chk("ro_clear", {31'd0, interrupt_clear_o}, 32'd0);
        repeat (2) cycle();
        rst_n_i = 1'b1;
        base_trig = trig_cnt;
        h = valid_cyc;
        repeat (20) cycle();
        chk("ro_no_trigger", trig_cnt - base_trig, 32'd0);
        chk("ro_no_valid", valid_cyc - h, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
